// File: rtl/at_req_fifo.sv
// Request FIFO feeding the negedge-capture latch stage: valid/ready in, one
// posedge-registered enable/data strobe out per take, with occupancy and flush.
module at_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  input  logic             out_take,
  output logic             out_e,
  output logic [WIDTH-1:0] out_d,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             push_s;
  logic             pop_s;

  assign empty    = (count == {(PTR_W + 1){1'b0}});
  assign full     = (count == FULL_CNT);
  assign in_ready = reset_l & ~full;
  assign push_s   = in_valid & in_ready & ~flush;
  assign pop_s    = out_take & ~empty & ~flush;

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // Pointers, occupancy and the single-cycle output strobe.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count    <= {(PTR_W + 1){1'b0}};
      out_e    <= 1'b0;
      out_d    <= {WIDTH{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count    <= {(PTR_W + 1){1'b0}};
      out_e    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
      end
      // A pop never reads the slot being written: that needs count == 0.
      if (pop_s) begin
        out_d    <= mem_r[rd_ptr_r];
        out_e    <= 1'b1;
        rd_ptr_r <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
      end else begin
        out_e    <= 1'b0;
      end
      case ({push_s, pop_s})
        2'b10:   count <= count + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   count <= count - {{PTR_W{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

endmodule
